// File: rtl/cover_pkg.sv
// Shared types and helpers for the toggle-coverage collector.
// Vector helpers work on a 64-bit view; callers zero-extend.
package cover_pkg;

  localparam int IDX_W = 64;
  localparam int COVER_TOTAL = 28338;
  localparam int VEC_W = 64;

  typedef logic [IDX_W-1:0] cover_idx_t;

  function automatic logic [VEC_W-1:0] lowest_one_hot(
    input logic [VEC_W-1:0] v
  );
    return v & (~v + 64'd1);
  endfunction

  function automatic logic [6:0] popcount(
    input logic [VEC_W-1:0] v
  );
    logic [6:0] n;
    n = '0;
    for (int i = 0; i < VEC_W; i++)
      n = n + {6'd0, v[i]};
    return n;
  endfunction

endpackage

// File: rtl/cover_idx_fifo.sv
// Small first-word-fall-through FIFO for emitted cover indices.
// Push while full is accepted only alongside a pop; empty pops are no-ops.
module cover_idx_fifo
  import cover_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = 64
) (
  input  logic         clock,
  input  logic         flush,
  input  logic         push,
  input  logic [W-1:0] data_in,
  output logic         full,
  input  logic         pop,
  output logic [W-1:0] data_out,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic         do_pop;
  logic         do_push;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign data_out = empty ? '0 : mem[rd_ptr[AW-1:0]];

  // Pointer update; flush empties the queue without touching storage.
  always_ff @(posedge clock) begin
    if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage write, no reset needed since empty masks the read.
  always_ff @(posedge clock) begin
    if (do_push && !flush)
      mem[wr_ptr[AW-1:0]] <= data_in;
  end

endmodule

// File: rtl/cover_toggle_collector.sv
// Hardware sink for a toggle-coverage group: sticky bitmap, hit
// counter and a once-only stream of newly covered global indices.
module cover_toggle_collector
  import cover_pkg::*;
#(
  parameter int              WIDTH       = 11,
  parameter longint unsigned COVER_INDEX = 0,
  parameter int              COVER_TOTAL = 28338,
  parameter int              FIFO_DEPTH  = 4,
  parameter int              IDX_W       = 64
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [WIDTH-1:0]           valid,
  input  logic                       clear,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [IDX_W-1:0]           out_index,
  output logic [$clog2(WIDTH+1)-1:0] hit_count,
  output logic                       all_covered
);

  localparam int CW = $clog2(WIDTH+1);

  logic [WIDTH-1:0] hit;
  logic [WIDTH-1:0] pending;
  logic [WIDTH-1:0] new_bits;
  logic [WIDTH-1:0] grant;
  logic [63:0]      new_ext;
  logic [63:0]      pend_ext;
  logic [63:0]      gr_ext;
  logic [6:0]       pos;
  logic             fifo_full;
  logic             fifo_empty;
  logic             pop;
  logic             can_push;
  logic             push;
  logic             wipe;
  logic [IDX_W-1:0] push_idx;

  assign wipe      = reset || clear;
  assign new_bits  = valid & ~hit;
  assign out_valid = !fifo_empty;
  assign pop       = out_valid && out_ready;
  assign can_push  = !fifo_full || pop;
  assign push      = |grant;

  // Lowest pending bit wins a FIFO slot when one is free this cycle.
  always_comb begin
    new_ext  = '0;
    pend_ext = '0;
    new_ext[WIDTH-1:0]  = new_bits;
    pend_ext[WIDTH-1:0] = pending;
    gr_ext = lowest_one_hot(pend_ext);
    grant  = can_push ? gr_ext[WIDTH-1:0] : '0;
    pos    = '0;
    for (int i = 0; i < WIDTH; i++)
      if (grant[i]) pos = 7'(i);
    push_idx = IDX_W'(COVER_INDEX) + IDX_W'(pos);
  end

  // Bitmap, pending set and counter; reset and clear both wipe them.
  always_ff @(posedge clock) begin
    if (wipe) begin
      hit         <= '0;
      pending     <= '0;
      hit_count   <= '0;
      all_covered <= 1'b0;
    end else begin
      hit         <= hit | valid;
      pending     <= (pending | new_bits) & ~grant;
      hit_count   <= hit_count + CW'(popcount(new_ext));
      all_covered <= &hit;
    end
  end

  cover_idx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (IDX_W)
  ) u_fifo (
    .clock    (clock),
    .flush    (wipe),
    .push     (push),
    .data_in  (push_idx),
    .full     (fifo_full),
    .pop      (pop),
    .data_out (out_index),
    .empty    (fifo_empty)
  );

endmodule

// File: doc/cover_toggle_collector.md
Name: cover_toggle_collector

Overview:
- Receiving end of the toggle-coverage report path: the hardware-side consumer of a per-cycle WIDTH-bit toggle valid vector, replacing the DPI sink for emulation/FPGA runs.
- Keeps a sticky hit bitmap, counts distinct covered points, and streams each newly covered global cover index exactly once over a valid/ready port.
- Sits between a GEN_w*_toggle-style instrumented group and the coverage uploader.

Parameters:
- WIDTH, 11, number of toggle points in the group (1..64).
- COVER_INDEX, 0, global index of bit 0 of valid.
- COVER_TOTAL, 28338, total cover points design-wide; informational only, no range check in RTL.
- FIFO_DEPTH, 4, entries in the output index FIFO (power of two, >=2).
- IDX_W, 64, width of an emitted cover index (matches longint).

Ports:
- clock  in  1  sole clock, all state on posedge.
- reset  in  1  synchronous, active-high.
- valid  in  WIDTH  toggle-hit vector; bit i set = point COVER_INDEX+i hit this cycle.
- clear  in  1  one-cycle pulse, wipes all coverage state.
- out_valid  out  1  out_index holds a newly covered index.
- out_ready  in  1  consumer accepts out_index this cycle.
- out_index  out  IDX_W  global cover index, COVER_INDEX+bit.
- hit_count  out  $clog2(WIDTH+1)  number of distinct points hit since reset/clear.
- all_covered  out  1  every bit of hit bitmap set.

Behaviour:
- Reset, synchronous, one cycle: hit=0, pending=0, FIFO empty, hit_count=0, out_valid=0, out_index=0, all_covered=0.
  - valid is ignored while reset is high.
- Each cycle with !reset && !clear:
  - new = valid & ~hit.
  - hit <= hit | valid.
  - pending <= (pending | new) & ~grant.
  - hit_count <= hit_count + popcount(new).
- Repeat hits of an already-hit bit change nothing.
- grant is a one-hot selection of the lowest set bit of the current registered pending.
  - It is issued only when the FIFO is not full, or when it is full and being popped in the same cycle.
  - grant pushes COVER_INDEX + bit_position (zero-extended to IDX_W) into the FIFO.
  - Exactly one push per cycle maximum.
- Latency: a hit bit that is alone and has lowest priority appears on out_valid 2 cycles after valid is sampled.
  - Cycle N: valid sampled, pending set.
  - Cycle N+1: granted, pushed.
  - Cycle N+2: out_valid=1.
- FIFO is first-word-fall-through from registered storage.
  - out_valid = !empty.
  - Pop on out_valid && out_ready.
  - out_index is stable while out_valid && !out_ready.
- Full FIFO: pending retains bits, so no index is ever lost.
  - The FIFO never overflows; popping from empty is a no-op.
- Ordering: indices leave in grant order, i.e. lowest bit first among pending bits, then FIFO order.
- all_covered is registered: 1 the cycle after hit becomes all-ones.
- clear (when !reset): same effect as reset on all state next cycle; valid in the same cycle is discarded.
  - Entries in flight in the FIFO are dropped.
  - If out_ready is high that cycle, the pop is harmless.
- reset has priority over clear.
- Reset or clear mid-stream: the output goes idle the next cycle; the previously emitted indices may be emitted again after new hits.

Decomposition:
- Package cover_pkg:
  - typedef cover_idx_t (IDX_W bits).
  - localparam COVER_TOTAL.
  - function lowest_one_hot(vector).
  - function popcount.
- One sub-module, cover_idx_fifo:
  - Parameterised by depth and data width.
  - Ports: push/data_in/full, pop/data_out/empty, sync flush.
- Top holds the bitmap, pending vector, arbiter and counter.

Test Plan:
- Single hit: reset 2 cycles, COVER_INDEX=100, valid=11'h004 for one cycle, out_ready=1.
  - Expect out_valid for exactly one cycle, 2 cycles later, with out_index=102; hit_count=1.
- Burst and repeat: valid=11'h7FF for one cycle, then 11'h7FF again, out_ready=1.
  - Expect 11 outputs with out_index 100..110 in ascending order, one per cycle, no duplicates.
  - Expect hit_count=11 and all_covered=1.
- Backpressure: out_ready=0, valid=11'h0FF.
  - FIFO fills to 4 (100..103) and out_index holds 100; the remaining 4 bits stay pending.
  - Raise out_ready: all 8 indices arrive in order, none lost.
- Clear collision: valid=11'h001 and clear=1 in the same cycle.
  - hit_count=0 next cycle and no output.
  - Then valid=11'h001: emits 100 again.
- Reset mid-stream: 5 indices queued with out_ready=0, assert reset 1 cycle.
  - out_valid=0, hit_count=0, all_covered=0 the next cycle.
- Boundary: WIDTH=1, COVER_INDEX=28337, valid=1.
  - out_index=28337, hit_count=1, all_covered=1.
